// File: rtl/mips_pkg.sv
// Shared pipeline constants: writeback control field layout, register-zero index
// and default datapath widths used by decode and writeback.
package mips_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;

    // Bit positions inside the 2-bit WB control field carried down the pipe.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: two combinational read ports, one write port,
// hardwired zero register and write-first bypass.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (wrAddr != ZERO_IDX)) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Write-first: a read of the register being written sees the new value now.
    always_comb begin
        rdDataA = regs[rdAddrA];
        if (rdAddrA == ZERO_IDX) begin
            rdDataA = '0;
        end else if (wrEn && (rdAddrA == wrAddr)) begin
            rdDataA = wrData;
        end
    end

    always_comb begin
        rdDataB = regs[rdAddrB];
        if (rdAddrB == ZERO_IDX) begin
            rdDataB = '0;
        end else if (wrEn && (rdAddrB == wrAddr)) begin
            rdDataB = wrData;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the register
// file, and tracks the sticky halt flag and committed-write count.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] MemOpReg,
    input  logic [DATA_W-1:0] ResultRTypeReg,
    input  logic [ADDR_W-1:0] WrRegReg,
    input  logic [1:0]        WBReg,
    input  logic              HaltReg,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB,
    output logic [DATA_W-1:0] WrData,
    output logic              WrEn,
    output logic              Halted,
    output logic [31:0]       WriteCount
);

    assign WrData = WBReg[WB_MEMTOREG] ? MemOpReg : ResultRTypeReg;

    // Gated by the registered flag so the halting instruction's own write lands.
    assign WrEn = WBReg[WB_REGWRITE] && (WrRegReg != ADDR_W'(REG_ZERO)) && !Halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            Halted     <= 1'b0;
            WriteCount <= '0;
        end else begin
            if (HaltReg) begin
                Halted <= 1'b1;
            end
            if (WrEn) begin
                WriteCount <= WriteCount + 32'd1;
            end
        end
    end

    regfile_2r1w #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) regs (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (WrEn),
        .wrAddr (WrRegReg),
        .wrData (WrData),
        .rdAddrA(RdAddrA),
        .rdAddrB(RdAddrB),
        .rdDataA(RdDataA),
        .rdDataB(RdDataB)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MemOpReg;
    logic [31:0] ResultRTypeReg;
    logic [4:0]  WrRegReg;
    logic [1:0]  WBReg;
    logic        HaltReg;
    logic [4:0]  RdAddrA;
    logic [4:0]  RdAddrB;
    logic [31:0] RdDataA;
    logic [31:0] RdDataB;
    logic [31:0] WrData;
    logic        WrEn;
    logic        Halted;
    logic [31:0] WriteCount;

    int assertCount = 0;
    int failCount   = 0;
    bit cmpEn       = 1'b0;

    // Behavioural model: architectural state as plain variables.
    logic [31:0] mdlRegs [32];
    bit          mdlHalted = 1'b0;
    logic [31:0] mdlCount  = 32'd0;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .MemOpReg      (MemOpReg),
        .ResultRTypeReg(ResultRTypeReg),
        .WrRegReg      (WrRegReg),
        .WBReg         (WBReg),
        .HaltReg       (HaltReg),
        .RdAddrA       (RdAddrA),
        .RdAddrB       (RdAddrB),
        .RdDataA       (RdDataA),
        .RdDataB       (RdDataB),
        .WrData        (WrData),
        .WrEn          (WrEn),
        .Halted        (Halted),
        .WriteCount    (WriteCount)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [31:0] mdlWrData();
        return WBReg[0] ? MemOpReg : ResultRTypeReg;
    endfunction

    function automatic bit mdlWrEn();
        return WBReg[1] && (WrRegReg != 5'd0) && !mdlHalted;
    endfunction

    function automatic logic [31:0] mdlRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (mdlWrEn() && a == WrRegReg) return mdlWrData();
        return mdlRegs[a];
    endfunction

    // Model state advances on the same edge the DUT commits.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mdlRegs[i] = 32'd0;
            mdlHalted = 1'b0;
            mdlCount  = 32'd0;
        end else begin
            if (mdlWrEn()) begin
                mdlRegs[WrRegReg] = mdlWrData();
                mdlCount = mdlCount + 32'd1;
            end
            if (HaltReg) mdlHalted = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            check("cmp_WrData", WrData, mdlWrData());
            check("cmp_WrEn", {31'd0, WrEn}, {31'd0, mdlWrEn()});
            check("cmp_RdDataA", RdDataA, mdlRead(RdAddrA));
            check("cmp_RdDataB", RdDataB, mdlRead(RdAddrB));
            check("cmp_Halted", {31'd0, Halted}, {31'd0, mdlHalted});
            check("cmp_WriteCount", WriteCount, mdlCount);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setWb(input logic [1:0] wb, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] wr);
        WBReg          = wb;
        MemOpReg       = mem;
        ResultRTypeReg = alu;
        WrRegReg       = wr;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        HaltReg = 1'b0;
        RdAddrA = 5'd0;
        RdAddrB = 5'd0;
        setWb(2'b00, 32'd0, 32'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cmpEn = 1'b1;

        // Reset state: every index on both ports reads zero.
        for (int i = 0; i < 32; i++) begin
            RdAddrA = 5'(i);
            RdAddrB = 5'(31 - i);
            @(negedge clk);
            check("rst_RdDataA", RdDataA, 32'd0);
            check("rst_RdDataB", RdDataB, 32'd0);
            stepEdge();
        end
        check("rst_Halted", {31'd0, Halted}, 32'd0);
        check("rst_WriteCount", WriteCount, 32'd0);

        // ALU result write, then load-data write to the same register.
        setWb(2'b10, 32'h0, 32'h0000_1234, 5'd5);
        RdAddrA = 5'd0;
        stepEdge();
        setWb(2'b00, 32'h0, 32'h0, 5'd0);
        RdAddrA = 5'd5;
        @(negedge clk);
        check("mux_alu_r5", RdDataA, 32'h0000_1234);
        stepEdge();
        setWb(2'b11, 32'hDEAD_BEEF, 32'h0, 5'd5);
        stepEdge();
        setWb(2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("mux_mem_r5", RdDataA, 32'hDEAD_BEEF);
        check("mux_count", WriteCount, 32'd2);
        stepEdge();

        // Same-cycle bypass on both ports.
        setWb(2'b10, 32'h0, 32'hCAFE_0001, 5'd7);
        RdAddrA = 5'd7;
        RdAddrB = 5'd7;
        @(negedge clk);
        check("byp_A", RdDataA, 32'hCAFE_0001);
        check("byp_B", RdDataB, 32'hCAFE_0001);
        check("byp_WrEn", {31'd0, WrEn}, 32'd1);
        stepEdge();

        // Register zero is never written and does not count.
        setWb(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0);
        RdAddrA = 5'd0;
        @(negedge clk);
        check("zero_WrEn", {31'd0, WrEn}, 32'd0);
        check("zero_rd", RdDataA, 32'd0);
        check("zero_WrData", WrData, 32'hFFFF_FFFF);
        stepEdge();
        setWb(2'b01, 32'hA5A5_A5A5, 32'h0, 5'd4);
        @(negedge clk);
        check("zero_count", WriteCount, 32'd3);
        check("memtoreg_only_WrData", WrData, 32'hA5A5_A5A5);
        check("memtoreg_only_WrEn", {31'd0, WrEn}, 32'd0);
        stepEdge();

        // Halt: the halting write commits, later writes are suppressed.
        setWb(2'b10, 32'h0, 32'h0000_0011, 5'd3);
        HaltReg = 1'b1;
        stepEdge();
        HaltReg = 1'b0;
        setWb(2'b10, 32'h0, 32'h0000_0022, 5'd3);
        RdAddrA = 5'd3;
        @(negedge clk);
        check("halt_flag", {31'd0, Halted}, 32'd1);
        check("halt_WrEn", {31'd0, WrEn}, 32'd0);
        check("halt_r3", RdDataA, 32'h0000_0011);
        check("halt_count", WriteCount, 32'd4);
        stepEdge();
        setWb(2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("halt_r3_after", RdDataA, 32'h0000_0011);
        check("halt_count_after", WriteCount, 32'd4);
        stepEdge();

        // Reset wins over a simultaneous write while halted.
        setWb(2'b10, 32'h0, 32'h0000_0055, 5'd9);
        reset = 1'b1;
        stepEdge();
        reset = 1'b0;
        setWb(2'b00, 32'h0, 32'h0, 5'd0);
        RdAddrA = 5'd9;
        @(negedge clk);
        check("midrst_r9", RdDataA, 32'd0);
        check("midrst_Halted", {31'd0, Halted}, 32'd0);
        check("midrst_count", WriteCount, 32'd0);
        stepEdge();

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            setWb(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) begin
                RdAddrA = WrRegReg;
            end else begin
                RdAddrA = 5'($urandom_range(0, 31));
            end
            RdAddrB = ($urandom_range(0, 2) == 0) ? RdAddrA : 5'($urandom_range(0, 31));
            HaltReg = ($urandom_range(0, 299) == 0);
            reset   = ($urandom_range(0, 249) == 0);
            stepEdge();
        end
        reset   = 1'b0;
        HaltReg = 1'b0;
        setWb(2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        cmpEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
